// File: rtl/instr_encoder_pkg.sv
// Shared CPU constants: op_class codes, RV32 opcodes, encoder FSM states.
package instr_encoder_pkg;

    // Instruction class codes presented on op_class; 12..15 are illegal
    localparam logic [3:0] OPC_ALU_R  = 4'd0;
    localparam logic [3:0] OPC_ALU_I  = 4'd1;
    localparam logic [3:0] OPC_LOAD   = 4'd2;
    localparam logic [3:0] OPC_STORE  = 4'd3;
    localparam logic [3:0] OPC_BRANCH = 4'd4;
    localparam logic [3:0] OPC_JAL    = 4'd5;
    localparam logic [3:0] OPC_JALR   = 4'd6;
    localparam logic [3:0] OPC_LUI    = 4'd7;
    localparam logic [3:0] OPC_AUIPC  = 4'd8;
    localparam logic [3:0] OPC_CSR    = 4'd9;
    localparam logic [3:0] OPC_ECALL  = 4'd10;
    localparam logic [3:0] OPC_EBREAK = 4'd11;

    // RV32 major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] WORD_ECALL  = 32'h0000_0073;
    localparam logic [31:0] WORD_EBREAK = 32'h0010_0073;

    // funct7 values accepted for R-type and shift-immediate forms
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Encoder FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ENCODE = 2'd1;
    localparam logic [1:0] ST_EMIT   = 2'd2;

    // True when v is representable as a signed value whose sign bit is v[msb],
    // i.e. bits [31:msb] are all copies of the sign.
    function automatic logic fits_signed(input logic [31:0] v, input logic [4:0] msb);
        logic [31:0] hi;
        hi = $unsigned($signed(v) >>> msb);
        return (hi == 32'h0000_0000) || (hi == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational RV32IM field packer with legality check.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  i_op_class,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_legal
);

    // Pack fields into the instruction word and judge whether the bundle is encodable
    always_comb begin
        o_word  = 32'h0000_0000;
        o_legal = 1'b0;
        case (i_op_class)
            OPC_ALU_R: begin
                o_word  = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OP_R};
                o_legal = (i_funct7 == F7_BASE) || (i_funct7 == F7_ALT) || (i_funct7 == F7_MULDIV);
            end
            OPC_ALU_I: begin
                if ((i_funct3 == 3'b001) || (i_funct3 == 3'b101)) begin
                    // Shifts: upper immediate bits come from funct7, shamt from imm[4:0]
                    o_word  = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, OP_I};
                    o_legal = (i_imm[31:5] == 27'd0) &&
                              ((i_funct7 == F7_BASE) || ((i_funct7 == F7_ALT) && (i_funct3 == 3'b101)));
                end else begin
                    o_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_I};
                    o_legal = fits_signed(i_imm, 5'd11);
                end
            end
            OPC_LOAD: begin
                o_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
                o_legal = fits_signed(i_imm, 5'd11) && (i_funct3 != 3'b011) &&
                          (i_funct3 != 3'b110) && (i_funct3 != 3'b111);
            end
            OPC_JALR: begin
                o_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_JALR};
                o_legal = fits_signed(i_imm, 5'd11);
            end
            OPC_STORE: begin
                o_word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_STORE};
                o_legal = fits_signed(i_imm, 5'd11) && (i_funct3 < 3'b011);
            end
            OPC_BRANCH: begin
                o_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], OP_BRANCH};
                o_legal = fits_signed(i_imm, 5'd12) && !i_imm[0] &&
                          (i_funct3 != 3'b010) && (i_funct3 != 3'b011);
            end
            OPC_JAL: begin
                o_word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
                o_legal = fits_signed(i_imm, 5'd20) && !i_imm[0];
            end
            OPC_LUI: begin
                o_word  = {i_imm[31:12], i_rd, OP_LUI};
                o_legal = (i_imm[11:0] == 12'h000);
            end
            OPC_AUIPC: begin
                o_word  = {i_imm[31:12], i_rd, OP_AUIPC};
                o_legal = (i_imm[11:0] == 12'h000);
            end
            OPC_CSR: begin
                // rs1 field carries either the source register or the zimm value
                o_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_SYSTEM};
                o_legal = (i_funct3 != 3'b000) && (i_funct3 != 3'b100);
            end
            OPC_ECALL: begin
                o_word  = WORD_ECALL;
                o_legal = 1'b1;
            end
            OPC_EBREAK: begin
                o_word  = WORD_EBREAK;
                o_legal = 1'b1;
            end
            default: begin
                o_word  = 32'h0000_0000;
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts field bundles, emits RV32IM words with addresses.
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [31:0] i_base_addr,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [3:0]  i_op_class,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_addr,
    output logic [31:0] o_out_word,
    output logic        o_enc_err,
    output logic [7:0]  o_err_count
);

    logic [1:0]  r_state;
    logic        r_armed;
    logic [3:0]  r_op_class;
    logic [2:0]  r_funct3;
    logic [6:0]  r_funct7;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [31:0] r_imm;
    logic        r_out_valid;
    logic [31:0] r_out_word;
    logic [31:0] r_addr;
    logic [7:0]  r_err_count;

    logic [31:0] w_word;
    logic        w_legal;
    logic        w_accept;
    logic        w_reject;

    instr_pack u_pack (
        .i_op_class (r_op_class),
        .i_funct3   (r_funct3),
        .i_funct7   (r_funct7),
        .i_rd       (r_rd),
        .i_rs1      (r_rs1),
        .i_rs2      (r_rs2),
        .i_imm      (r_imm),
        .o_word     (w_word),
        .o_legal    (w_legal)
    );

    // r_armed holds in_ready low until the first clock edge after reset
    assign o_in_ready  = r_armed && (r_state == ST_IDLE) && !i_start;
    assign w_accept    = i_in_valid && o_in_ready;
    // A start in ENCODE aborts the bundle, so it neither flags nor counts
    assign w_reject    = (r_state == ST_ENCODE) && !w_legal && !i_start;
    assign o_enc_err   = w_reject;
    assign o_out_valid = r_out_valid;
    assign o_out_word  = r_out_word;
    assign o_out_addr  = r_addr;
    assign o_err_count = r_err_count;

    // Arm the input handshake one edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Capture the whole field bundle on an accepted handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_class <= 4'd0;
            r_funct3   <= 3'd0;
            r_funct7   <= 7'd0;
            r_rd       <= 5'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_imm      <= 32'd0;
        end else if (w_accept) begin
            r_op_class <= i_op_class;
            r_funct3   <= i_funct3;
            r_funct7   <= i_funct7;
            r_rd       <= i_rd;
            r_rs1      <= i_rs1;
            r_rs2      <= i_rs2;
            r_imm      <= i_imm;
        end
    end

    // Main FSM with output word and address counter; start overrides any state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_word  <= 32'd0;
            r_addr      <= 32'd0;
        end else if (i_start) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_addr      <= i_base_addr & 32'hFFFF_FFFC;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    if (w_legal) begin
                        r_state     <= ST_EMIT;
                        r_out_valid <= 1'b1;
                        r_out_word  <= w_word;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_EMIT: begin
                    // Word and address hold until the consumer takes them
                    if (i_out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_addr      <= r_addr + 32'd4;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of rejected bundles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= 8'd0;
        end else if (w_reject && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder with hand-computed expected words.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_base_addr = 32'd0;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic [3:0]  i_op_class = 4'd0;
    logic [2:0]  i_funct3 = 3'd0;
    logic [6:0]  i_funct7 = 7'd0;
    logic [4:0]  i_rd = 5'd0;
    logic [4:0]  i_rs1 = 5'd0;
    logic [4:0]  i_rs2 = 5'd0;
    logic [31:0] i_imm = 32'd0;
    logic        o_out_valid;
    logic        i_out_ready = 1'b1;
    logic [31:0] o_out_addr;
    logic [31:0] o_out_word;
    logic        o_enc_err;
    logic [7:0]  o_err_count;

    int checks = 0;
    int errors = 0;

    instr_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_op_class  (i_op_class),
        .i_funct3    (i_funct3),
        .i_funct7    (i_funct7),
        .i_rd        (i_rd),
        .i_rs1       (i_rs1),
        .i_rs2       (i_rs2),
        .i_imm       (i_imm),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_addr  (o_out_addr),
        .o_out_word  (o_out_word),
        .o_enc_err   (o_enc_err),
        .o_err_count (o_err_count)
    );

    always #5 clk = ~clk;

    // Present a bundle at a falling edge and hold it until accepted; returns at the
    // falling edge of the ENCODE cycle.
    task automatic send(input logic [3:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        int n;
        n = 0;
        @(negedge clk);
        i_op_class = opc; i_funct3 = f3; i_funct7 = f7;
        i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm;
        i_in_valid = 1'b1;
        while (!o_in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", o_in_ready, n);
        end
        @(negedge clk);
        i_in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] base);
        @(negedge clk);
        i_start = 1'b1;
        i_base_addr = base;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", o_out_valid); end
        checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0", o_in_ready); end
        checks++; if (o_out_addr !== 32'h0) begin errors++; $display("FAIL rst_out_addr: got %h, required 0", o_out_addr); end
        checks++; if (o_out_word !== 32'h0) begin errors++; $display("FAIL rst_out_word: got %h, required 0", o_out_word); end
        checks++; if (o_enc_err !== 1'b0) begin errors++; $display("FAIL rst_enc_err: got %b, required 0", o_enc_err); end
        checks++; if (o_err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count: got %0d, required 0", o_err_count); end
        rst_n = 1'b1;
        #1;
        checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL rst_release_in_ready: got %b, required 0", o_in_ready); end
        @(negedge clk);
        checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b, required 1", o_in_ready); end
    endtask

    task automatic test_basic();
        do_start(32'h0000_0100);
        send(OPC_ALU_I, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency: out_valid=%b one cycle after accept, required 0", o_out_valid); end
        checks++; if (o_enc_err !== 1'b0) begin errors++; $display("FAIL basic_enc_err: got %b, required 0", o_enc_err); end
        @(negedge clk);
        checks++; if (o_out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b, required 1", o_out_valid); end
        checks++; if (o_out_word !== 32'h0050_0093) begin errors++; $display("FAIL basic_word: got %h, required 00500093", o_out_word); end
        checks++; if (o_out_addr !== 32'h0000_0100) begin errors++; $display("FAIL basic_addr: got %h, required 00000100", o_out_addr); end
        @(negedge clk);
        checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL basic_done_valid: got %b, required 0", o_out_valid); end
        checks++; if (o_out_addr !== 32'h0000_0104) begin errors++; $display("FAIL basic_next_addr: got %h, required 00000104", o_out_addr); end
    endtask

    task automatic test_backpressure();
        i_out_ready = 1'b0;
        send(OPC_ALU_R, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checks++; if (o_out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b, required 1", k, o_out_valid); end
            checks++; if (o_out_word !== 32'h0020_81B3) begin errors++; $display("FAIL bp_word[%0d]: got %h, required 002081b3", k, o_out_word); end
            checks++; if (o_out_addr !== 32'h0000_0104) begin errors++; $display("FAIL bp_addr[%0d]: got %h, required 00000104", k, o_out_addr); end
            @(negedge clk);
        end
        i_out_ready = 1'b1;
        @(negedge clk);
        checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b, required 0", o_out_valid); end
        checks++; if (o_out_addr !== 32'h0000_0108) begin errors++; $display("FAIL bp_next_addr: got %h, required 00000108", o_out_addr); end
    endtask

    task automatic test_encodings();
        logic [3:0]  opc [8] = '{OPC_BRANCH, OPC_JAL, OPC_LUI, OPC_EBREAK, OPC_ALU_I, OPC_ALU_I, OPC_STORE, OPC_CSR};
        logic [2:0]  f3  [8] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b101, 3'b010, 3'b001};
        logic [6:0]  f7  [8] = '{7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'b0100000, 7'd0, 7'd0};
        logic [4:0]  rd  [8] = '{5'd0, 5'd1, 5'd5, 5'd0, 5'd1, 5'd1, 5'd0, 5'd1};
        logic [4:0]  rs1 [8] = '{5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 5'd1, 5'd2};
        logic [4:0]  rs2 [8] = '{5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0};
        logic [31:0] imm [8] = '{32'd8, 32'd16, 32'h1234_5000, 32'd0, 32'hFFFF_F800, 32'd31, 32'hFFFF_FFFC, 32'h0000_0300};
        logic [31:0] exp [8] = '{32'h0020_8463, 32'h0100_00EF, 32'h1234_52B7, 32'h0010_0073,
                                 32'h8000_0093, 32'h41F1_5093, 32'hFE20_AE23, 32'h3001_10F3};
        logic [31:0] addr;
        addr = 32'h0000_0108;
        for (int k = 0; k < 8; k++) begin
            send(opc[k], f3[k], f7[k], rd[k], rs1[k], rs2[k], imm[k]);
            checks++; if (o_enc_err !== 1'b0) begin errors++; $display("FAIL enc_err[%0d]: got %b, required 0", k, o_enc_err); end
            @(negedge clk);
            checks++; if (o_out_valid !== 1'b1) begin errors++; $display("FAIL enc_valid[%0d]: got %b, required 1", k, o_out_valid); end
            checks++; if (o_out_word !== exp[k]) begin errors++; $display("FAIL enc_word[%0d]: got %h, required %h", k, o_out_word, exp[k]); end
            checks++; if (o_out_addr !== addr) begin errors++; $display("FAIL enc_addr[%0d]: got %h, required %h", k, o_out_addr, addr); end
            addr = addr + 32'd4;
        end
        @(negedge clk);
        checks++; if (o_out_addr !== 32'h0000_0128) begin errors++; $display("FAIL enc_final_addr: got %h, required 00000128", o_out_addr); end
    endtask

    task automatic test_illegal();
        logic [3:0]  opc [3] = '{OPC_BRANCH, OPC_LUI, 4'hF};
        logic [31:0] imm [3] = '{32'd7, 32'h1234_5001, 32'd0};
        for (int k = 0; k < 3; k++) begin
            send(opc[k], 3'b000, 7'd0, 5'd1, 5'd1, 5'd2, imm[k]);
            checks++; if (o_enc_err !== 1'b1) begin errors++; $display("FAIL ill_enc_err[%0d]: got %b, required 1", k, o_enc_err); end
            @(negedge clk);
            checks++; if (o_enc_err !== 1'b0) begin errors++; $display("FAIL ill_err_pulse[%0d]: got %b, required 0", k, o_enc_err); end
            checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL ill_valid[%0d]: got %b, required 0", k, o_out_valid); end
        end
        checks++; if (o_err_count !== 8'd3) begin errors++; $display("FAIL ill_count: got %0d, required 3", o_err_count); end
        checks++; if (o_out_addr !== 32'h0000_0128) begin errors++; $display("FAIL ill_addr: got %h, required 00000128", o_out_addr); end
        for (int k = 0; k < 300; k++) begin
            case (k % 4)
                0: send(OPC_ALU_I, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
                1: send(OPC_ALU_I, 3'b001, 7'b0100000, 5'd1, 5'd0, 5'd0, 32'd3);
                2: send(OPC_LOAD, 3'b011, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
                default: send(OPC_JAL, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
            endcase
        end
        @(negedge clk);
        checks++; if (o_err_count !== 8'd255) begin errors++; $display("FAIL ill_saturate: got %0d, required 255", o_err_count); end
        checks++; if (o_out_addr !== 32'h0000_0128) begin errors++; $display("FAIL ill_addr_after: got %h, required 00000128", o_out_addr); end
    endtask

    task automatic test_wrap();
        do_start(32'hFFFF_FFFF);
        checks++; if (o_out_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_base: got %h, required fffffffc", o_out_addr); end
        checks++; if (o_err_count !== 8'd255) begin errors++; $display("FAIL wrap_count_kept: got %0d, required 255", o_err_count); end
        send(OPC_ALU_I, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(negedge clk);
        checks++; if (o_out_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h, required fffffffc", o_out_addr); end
        send(OPC_ECALL, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        @(negedge clk);
        checks++; if (o_out_word !== 32'h0000_0073) begin errors++; $display("FAIL wrap_word1: got %h, required 00000073", o_out_word); end
        checks++; if (o_out_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr1: got %h, required 00000000", o_out_addr); end
        @(negedge clk);
    endtask

    task automatic test_abort_emit();
        do_start(32'h0000_0200);
        i_out_ready = 1'b0;
        send(OPC_ALU_I, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(negedge clk);
        checks++; if (o_out_valid !== 1'b1) begin errors++; $display("FAIL abort_pre_valid: got %b, required 1", o_out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL rst_emit_valid: got %b, required 0", o_out_valid); end
        checks++; if (o_out_addr !== 32'h0) begin errors++; $display("FAIL rst_emit_addr: got %h, required 0", o_out_addr); end
        checks++; if (o_err_count !== 8'd0) begin errors++; $display("FAIL rst_emit_count: got %0d, required 0", o_err_count); end
        @(negedge clk);
        rst_n = 1'b1;
        do_start(32'h0000_0300);
        send(OPC_ALU_I, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(negedge clk);
        checks++; if (o_out_valid !== 1'b1) begin errors++; $display("FAIL start_pre_valid: got %b, required 1", o_out_valid); end
        i_start = 1'b1;
        i_base_addr = 32'h0000_0400;
        #1;
        checks++; if (o_out_valid !== 1'b1) begin errors++; $display("FAIL start_same_cycle_valid: got %b, required 1", o_out_valid); end
        @(negedge clk);
        checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL start_emit_valid: got %b, required 0", o_out_valid); end
        checks++; if (o_out_addr !== 32'h0000_0400) begin errors++; $display("FAIL start_emit_addr: got %h, required 00000400", o_out_addr); end
        checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL start_in_ready: got %b, required 0", o_in_ready); end
        i_start = 1'b0;
        i_out_ready = 1'b1;
        @(negedge clk);
        checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL after_start_in_ready: got %b, required 1", o_in_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_encodings();
        test_illegal();
        test_wrap();
        test_abort_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
